bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 17 +
 rtl/rr_pick.sv | 46 ++++
 rtl/bus_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter: state encoding and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bus_pkg;

    // Default number of requesters and default maximum grant tenure in cycles.
    localparam int BUS_N_DEF          = 4;
    localparam int BUS_MAX_TENURE_DEF = 16;

    // Arbiter FSM states. ST_TURN is the single bus-release cycle between grants.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } bus_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set req bit scanning upward from last+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; vld is low when no request is pending.
//
// Ports:
//   req  - per-requester request vector
//   last - index of the most recent grant (lowest priority in this search)
//   vld  - at least one request is set
//   id   - index of the winning requester, meaningful while vld=1
module rr_pick
    import bus_pkg::*;
#(
    parameter int N = BUS_N_DEF
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 vld,
    output logic [$clog2(N)-1:0] id
);

    localparam int IW = $clog2(N);

    int          cand;
    logic [IW-1:0] cand_w;

    always_comb begin
        vld    = 1'b0;
        id     = '0;
        cand   = 0;
        cand_w = '0;
        // Offset k=N wraps back to last itself, so a lone requester that was
        // just served can still win.
        for (int k = 1; k <= N; k++) begin
            cand = int'(last) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_w = IW'(cand);
            if (!vld && req[cand_w]) begin
                vld = 1'b1;
                id  = cand_w;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with bounded tenure and a one-cycle turnaround between grants.
// Latency: req sampled at edge k gives gnt after edge k; one gnt=0 cycle between grants.
// Backpressure: requesters hold req until granted; a grant ends on req drop or MAX_TENURE.
//
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   req    - level-sensitive request per requester
//   gnt    - registered one-hot grant, drives each requester's buffer enable
//   gnt_id - binary index of the granted requester, valid while busy=1
//   busy   - high exactly when gnt is nonzero
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N          = BUS_N_DEF,
    parameter int MAX_TENURE = BUS_MAX_TENURE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int TW = $clog2(MAX_TENURE + 1);

    bus_state_e    state_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gnt_id_q;
    logic [IW-1:0] last_q;
    logic [TW-1:0] tenure_q;

    logic          pick_vld;
    logic [IW-1:0] pick_id;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req  (req),
        .last (last_q),
        .vld  (pick_vld),
        .id   (pick_id)
    );

    // gnt is a register so the buffer enables never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            last_q   <= IW'(N - 1);
            tenure_q <= '0;
        end else begin
            case (state_q)
                // IDLE and TURN arbitrate identically; TURN only differs in
                // being entered from a grant.
                ST_IDLE, ST_TURN: begin
                    if (pick_vld) begin
                        state_q  <= ST_GRANT;
                        gnt_q    <= {{(N-1){1'b0}}, 1'b1} << pick_id;
                        gnt_id_q <= pick_id;
                        last_q   <= pick_id;
                        tenure_q <= TW'(1);
                    end else begin
                        state_q  <= ST_IDLE;
                        gnt_q    <= '0;
                        tenure_q <= '0;
                    end
                end
                ST_GRANT: begin
                    // Other req bits are ignored here; only the owner's req
                    // and the tenure limit can end the grant.
                    if (!req[gnt_id_q] || (tenure_q == TW'(MAX_TENURE))) begin
                        state_q  <= ST_TURN;
                        gnt_q    <= '0;
                        tenure_q <= '0;
                    end else begin
                        tenure_q <= tenure_q + TW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    gnt_q    <= '0;
                    tenure_q <= '0;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = |gnt_q;

endmodule
